kims_uart_tx: RTL and testbench

Byte-serialising output stage for the kims123 TinyTapeout design. It sits directly downstream of the core logic inside `tt_um_giffel1_kims123` and consumes the 8-bit result bytes that the core would otherwise present on `uo_out`. Bytes are buffered in a small FIFO and shifted out LSB-first as 8N1 UART frames on a single pin, which the top level routes to `uo_out[0]`. This lets the cocotb bench and bench hardware read results over one wire.

---
 rtl/kims_uart_tx.sv | 206 ++++++++++++++++++++
 tb/tb_kims_uart_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/kims_uart_tx.sv
// kims_uart_tx: FIFO-buffered LSB-first UART transmitter (8N1 by default).
// Define KIMS_UART_PARITY_EN to add an even-parity bit (8E1 frames).
module kims_uart_tx #(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam int              CW         = AW + 1;
    localparam logic [15:0]     BAUD_LOAD  = 16'(CLK_DIV - 1);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef KIMS_UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef KIMS_UART_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    state_t         r_state;
    logic [7:0]     r_shift;
    logic [2:0]     r_bit_idx;
    logic [15:0]    r_baud;
    logic           r_tx;
    logic           r_busy;
`ifdef KIMS_UART_PARITY_EN
    logic           r_parity;
`endif

    logic           w_full;
    logic           w_empty;
    logic           w_wr;
    logic           w_pop;
    logic           w_bit_end;
    logic [7:0]     w_head;

    // FIFO flags, write/pop strobes and end-of-bit detection
    always_comb begin
        w_full    = (r_count == FULL_COUNT);
        w_empty   = (r_count == {CW{1'b0}});
        w_wr      = in_valid & ~w_full;
        w_bit_end = (r_baud == 16'd0);
        w_head    = r_mem[r_rd_ptr];
        case (r_state)
            ST_IDLE: w_pop = ~w_empty;
            ST_STOP: w_pop = w_bit_end & ~w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    // FIFO storage; only accepted writes touch the array so X on in_data stays out
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous write and pop cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer with registered line and busy outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
            r_baud    <= 16'd0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef KIMS_UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_head;
`ifdef KIMS_UART_PARITY_EN
                        r_parity <= even_parity(w_head);
`endif
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_baud   <= BAUD_LOAD;
                        r_state  <= ST_START;
                    end else begin
                        r_tx     <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_bit_idx <= 3'd0;
                        r_baud    <= BAUD_LOAD;
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud    <= r_baud - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= BAUD_LOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef KIMS_UART_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_tx      <= r_shift[1];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
`ifdef KIMS_UART_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_baud  <= BAUD_LOAD;
                        r_state <= ST_STOP;
                    end else begin
                        r_baud  <= r_baud - 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        // Queued data starts the next start bit with no idle gap
                        if (w_pop) begin
                            r_shift  <= w_head;
`ifdef KIMS_UART_PARITY_EN
                            r_parity <= even_parity(w_head);
`endif
                            r_tx     <= 1'b0;
                            r_baud   <= BAUD_LOAD;
                            r_state  <= ST_START;
                        end else begin
                            r_tx     <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = ~w_full;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_level = r_count;

endmodule

// File: tb/tb_kims_uart_tx.sv
// Directed, table-driven bench for kims_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
module tb_kims_uart_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef KIMS_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    kims_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] exp_n;   // line value per bit-time, bit 0 = start bit
        logic [10:0] exp_e;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef KIMS_UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Checks frame samples first..FRAME-1; sample s is the one after the (s+1)th edge of the frame
    task automatic check_frame(input string name, input logic [10:0] exp, input int first);
        for (int s = first; s < FRAME; s++) begin
            tick();
            chk($sformatf("%s tx bit%0d", name, s / CLK_DIV), {31'd0, tx}, {31'd0, exp[s / CLK_DIV]});
            chk($sformatf("%s busy", name), {31'd0, busy}, 32'd1);
        end
    endtask

    initial begin
        logic [10:0] exp;

        vecs[0] = '{8'hA5, 10'b1_10100101_0, 11'b1_0_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0, 11'b1_0_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0, 11'b1_0_11111111_0};
        vecs[3] = '{8'h3C, 10'b1_00111100_0, 11'b1_0_00111100_0};
        vecs[4] = '{8'h07, 10'b1_00000111_0, 11'b1_1_00000111_0};
        vecs[5] = '{8'h03, 10'b1_00000011_0, 11'b1_0_00000011_0};
        vecs[6] = '{8'h80, 10'b1_10000000_0, 11'b1_1_10000000_0};

        // Reset and idle
        do_reset();
        for (int c = 0; c < 50; c++) begin
            chk("idle tx", {31'd0, tx}, 32'd1);
            chk("idle busy", {31'd0, busy}, 32'd0);
            chk("idle level", {29'd0, fifo_level}, 32'd0);
            chk("idle in_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end

        // Single frames from the vector table
        for (int i = 0; i < 7; i++) begin
`ifdef KIMS_UART_PARITY_EN
            exp = vecs[i].exp_e;
`else
            exp = vecs[i].exp_n;
`endif
            chk("vec in_ready", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            tick();
            in_valid = 1'b0;
            in_data  = 8'hxx;
            chk("vec level after write", {29'd0, fifo_level}, 32'd1);
            chk("vec tx before pop", {31'd0, tx}, 32'd1);
            check_frame($sformatf("vec%0h", vecs[i].data), exp, 0);
            tick();
            chk("vec busy end", {31'd0, busy}, 32'd0);
            chk("vec tx end", {31'd0, tx}, 32'd1);
            chk("vec level end", {29'd0, fifo_level}, 32'd0);
            repeat (3) tick();
        end

        // Five consecutive writes, sixth refused, back-to-back frames
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(i + 1);
            chk($sformatf("burst in_ready w%0d", i), {31'd0, in_ready}, 32'd1);
            tick();
            if (i >= 1) begin
                chk("burst start tx", {31'd0, tx}, 32'd0);
                chk("burst start busy", {31'd0, busy}, 32'd1);
            end
        end
        chk("burst full in_ready", {31'd0, in_ready}, 32'd0);
        chk("burst full level", {29'd0, fifo_level}, 32'd4);
        in_data = 8'h06;
        tick();
        in_valid = 1'b0;
        chk("burst refused level", {29'd0, fifo_level}, 32'd4);
        check_frame("burst f1", frame_of(8'h01), 5);
        for (int f = 2; f <= 5; f++) begin
            check_frame($sformatf("burst f%0d", f), frame_of(8'(f)), 0);
        end
        tick();
        chk("burst busy end", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 20; c++) begin
            chk("burst no sixth frame", {31'd0, tx}, 32'd1);
            tick();
        end

        // Full FIFO with in_valid held across the pop cycle
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h11;
        tick();
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h21 + 8'(i);
            tick();
        end
        in_data = 8'h99;
        chk("fill level", {29'd0, fifo_level}, 32'd4);
        chk("fill in_ready", {31'd0, in_ready}, 32'd0);
        repeat (FRAME - 4) tick();
        chk("fill stop tx", {31'd0, tx}, 32'd1);
        chk("fill pre-pop level", {29'd0, fifo_level}, 32'd4);
        chk("fill pre-pop in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("fill pop level", {29'd0, fifo_level}, 32'd3);
        chk("fill next start", {31'd0, tx}, 32'd0);
        check_frame("fill f2", frame_of(8'h21), 1);

        // Reset in the middle of a data bit with two bytes queued
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_data  = 8'h55;
        tick();
        in_data  = 8'h66;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk("rst pre tx (3C bit1)", {31'd0, tx}, 32'd0);
        chk("rst pre level", {29'd0, fifo_level}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("rst async tx", {31'd0, tx}, 32'd1);
        chk("rst async level", {29'd0, fifo_level}, 32'd0);
        chk("rst async busy", {31'd0, busy}, 32'd0);
        chk("rst async in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            chk("post-rst tx", {31'd0, tx}, 32'd1);
            chk("post-rst busy", {31'd0, busy}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
